// File: rtl/imem_loader_pkg.sv
// Shared types and helpers for the instruction-memory loader.
// The checksum helper is only used when IMEM_LOADER_CHECKSUM_EN is defined.
package imem_loader_pkg;

    localparam int WORD_BYTES = 4;
    localparam int CNT_BYTES  = 2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CNT_HI,
        ST_CNT_LO,
        ST_DATA,
        ST_CHK,
        ST_DONE,
        ST_ERR
    } loader_state_e;

    // Folds all four bytes of a packed word into the running XOR checksum.
    function automatic logic [7:0] chk_fold(input logic [7:0] acc, input logic [31:0] word);
        return acc ^ word[31:24] ^ word[23:16] ^ word[15:8] ^ word[7:0];
    endfunction

endpackage

// File: rtl/imem_loader_if.sv
// Byte-stream, instruction-memory write port and status bundle of the loader.
interface imem_loader_if #(parameter int ADDR_W = 10);

    logic              start;
    logic [7:0]        rx_data;
    logic              rx_valid;
    logic              rx_ready;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;
    logic              cpu_hold;
    logic              done;
    logic              error;
    logic [ADDR_W:0]   words_loaded;

    modport slave (
        input  start, rx_data, rx_valid,
        output rx_ready, imem_we, imem_addr, imem_wdata,
               cpu_hold, done, error, words_loaded
    );

    modport master (
        output start, rx_data, rx_valid,
        input  rx_ready, imem_we, imem_addr, imem_wdata,
               cpu_hold, done, error, words_loaded
    );

endinterface

// File: rtl/imem_byte_packer.sv
// Big-endian 8->32 packer: the first byte of a word lands in bits 31:24.
module imem_byte_packer
    import imem_loader_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clear,
    input  logic        en,
    input  logic [7:0]  rx_byte,
    output logic        word_valid,
    output logic [31:0] word
);

    logic [23:0] shift_q;
    logic [1:0]  idx_q;

    // The byte index wraps naturally after the fourth byte of each word.
    always_ff @(posedge clk) begin
        if (!rst_n || clear) begin
            shift_q <= '0;
            idx_q   <= '0;
        end else if (en) begin
            shift_q <= {shift_q[15:0], rx_byte};
            idx_q   <= idx_q + 2'd1;
        end
    end

    assign word_valid = en && (idx_q == 2'(WORD_BYTES - 1));
    assign word       = {shift_q, rx_byte};

endmodule

// File: rtl/imem_loader.sv
// Runtime program loader: count header, big-endian words, optional checksum
// byte (enabled by defining IMEM_LOADER_CHECKSUM_EN); writes imem from address 0.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int ADDR_W = 10
)
(
    input  logic         clk,
    input  logic         rst_n,
    imem_loader_if.slave bus
);

    loader_state_e     state_q, state_d;
    logic [7:0]        cnt_hi_q;
    logic [ADDR_W:0]   n_q;
    logic [ADDR_W:0]   words_rcvd_q;
    logic [ADDR_W:0]   loaded_q;
    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       wdata_q;
    logic              rx_ready;
    logic              hs;
    logic              start_ok;
    logic              data_complete;
    logic              pack_en;
    logic              word_valid;
    logic [31:0]       word;
    logic [15:0]       n_full;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0]        chk_q;
    logic              last_word;
`endif

    assign hs            = bus.rx_valid && rx_ready;
    assign start_ok      = bus.start && (state_q == ST_IDLE || state_q == ST_DONE || state_q == ST_ERR);
    assign n_full        = {cnt_hi_q, bus.rx_data};
    assign data_complete = (words_rcvd_q == n_q);
    assign pack_en       = hs && (state_q == ST_DATA);
`ifdef IMEM_LOADER_CHECKSUM_EN
    assign last_word     = ((words_rcvd_q + (ADDR_W+1)'(1)) == n_q);
`endif

    imem_byte_packer u_packer (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear      (start_ok),
        .en         (pack_en),
        .rx_byte    (bus.rx_data),
        .word_valid (word_valid),
        .word       (word)
    );

    // Once every word is received the stream is closed so the drain cycle
    // before DONE cannot swallow a stray byte.
    always_comb begin
        rx_ready = 1'b0;
        case (state_q)
            ST_CNT_HI, ST_CNT_LO: rx_ready = 1'b1;
            ST_DATA:              rx_ready = !data_complete;
`ifdef IMEM_LOADER_CHECKSUM_EN
            ST_CHK:               rx_ready = 1'b1;
`endif
            default:              rx_ready = 1'b0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE, ST_DONE, ST_ERR: begin
                if (bus.start) state_d = ST_CNT_HI;
            end
            ST_CNT_HI: begin
                if (hs) state_d = ST_CNT_LO;
            end
            ST_CNT_LO: begin
                if (hs) begin
                    if (32'(n_full) > (32'd1 << ADDR_W)) begin
                        state_d = ST_ERR;
                    end else if (n_full == 16'd0) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                        state_d = ST_CHK;
`else
                        state_d = ST_DONE;
`endif
                    end else begin
                        state_d = ST_DATA;
                    end
                end
            end
            ST_DATA: begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                if (word_valid && last_word) state_d = ST_CHK;
`else
                if (data_complete) state_d = ST_DONE;
`endif
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            ST_CHK: begin
                if (hs) state_d = (bus.rx_data == chk_q) ? ST_DONE : ST_ERR;
            end
`endif
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            cnt_hi_q     <= '0;
            n_q          <= '0;
            words_rcvd_q <= '0;
            loaded_q     <= '0;
            we_q         <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            chk_q        <= '0;
`endif
        end else begin
            state_q <= state_d;
            we_q    <= word_valid;
            if (hs && state_q == ST_CNT_HI) cnt_hi_q <= bus.rx_data;
            if (hs && state_q == ST_CNT_LO) n_q <= n_full[ADDR_W:0];
            if (word_valid) begin
                words_rcvd_q <= words_rcvd_q + (ADDR_W+1)'(1);
                addr_q       <= words_rcvd_q[ADDR_W-1:0];
                wdata_q      <= word;
`ifdef IMEM_LOADER_CHECKSUM_EN
                chk_q        <= chk_fold(chk_q, word);
`endif
            end
            if (we_q) loaded_q <= loaded_q + (ADDR_W+1)'(1);
            if (start_ok) begin
                words_rcvd_q <= '0;
                loaded_q     <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
                chk_q        <= '0;
`endif
            end
        end
    end

    assign bus.rx_ready     = rx_ready;
    assign bus.imem_we      = we_q;
    assign bus.imem_addr    = addr_q;
    assign bus.imem_wdata   = wdata_q;
    assign bus.cpu_hold     = !(state_q == ST_IDLE || state_q == ST_DONE);
    assign bus.done         = (state_q == ST_DONE);
    assign bus.error        = (state_q == ST_ERR);
    assign bus.words_loaded = loaded_q;

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: expected writes are queued as bytes are sent
// and popped by a monitor on every imem_we. Honours IMEM_LOADER_CHECKSUM_EN.
module tb_imem_loader;

    localparam int ADDR_W    = 10;
    localparam int MAX_WORDS = 1 << ADDR_W;

    typedef struct {
        int          addr;
        logic [31:0] data;
        int          cyc;
    } wr_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   vectors = 0;
    int   miscompares = 0;
    wr_t  exp_q[$];
    wr_t  mon_e;
    logic [31:0] load_words[$];

    imem_loader_if #(.ADDR_W(ADDR_W)) bus();

    imem_loader #(.ADDR_W(ADDR_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("[TB] FAIL %s: actual %0h required %0h", name, act, req);
        end
    endtask

    // Monitor: every write strobe must match the oldest expected write, in the right cycle.
    always @(negedge clk) begin
        if (bus.imem_we !== 1'b0) begin
            if (exp_q.size() == 0) begin
                checkOutput("unexpected imem_we", 64'(bus.imem_we), 64'd0);
            end else begin
                mon_e = exp_q.pop_front();
                checkOutput("write addr", 64'(bus.imem_addr), 64'(mon_e.addr));
                checkOutput("write data", 64'(bus.imem_wdata), 64'(mon_e.data));
                checkOutput("write cycle", 64'(cyc), 64'(mon_e.cyc));
            end
        end
    end

    task automatic sendByte(input logic [7:0] b, input bit gaps, output int hs_cyc);
        int waited;
        waited = 0;
        if (gaps) repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
        bus.rx_data  = b;
        bus.rx_valid = 1'b1;
        @(negedge clk);
        while (!bus.rx_ready && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        if (!bus.rx_ready) checkOutput("rx_ready timeout", 64'd0, 64'd1);
        @(posedge clk); #1;
        hs_cyc       = cyc;
        bus.rx_valid = 1'b0;
    endtask

    task automatic waitStatus(output int seen);
        seen = -1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus.done || bus.error) begin
                seen = cyc;
                break;
            end
        end
        if (seen < 0) checkOutput("status timeout", 64'd0, 64'd1);
        @(posedge clk); #1;
    endtask

    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, " rx_ready"}, 64'(bus.rx_ready), 64'd0);
        checkOutput({tag, " imem_we"}, 64'(bus.imem_we), 64'd0);
        checkOutput({tag, " imem_addr"}, 64'(bus.imem_addr), 64'd0);
        checkOutput({tag, " imem_wdata"}, 64'(bus.imem_wdata), 64'd0);
        checkOutput({tag, " cpu_hold"}, 64'(bus.cpu_hold), 64'd0);
        checkOutput({tag, " done"}, 64'(bus.done), 64'd0);
        checkOutput({tag, " error"}, 64'(bus.error), 64'd0);
        checkOutput({tag, " words_loaded"}, 64'(bus.words_loaded), 64'd0);
    endtask

    task automatic fillRandom(input int n);
        load_words.delete();
        for (int i = 0; i < n; i++) load_words.push_back($urandom);
    endtask

    // One complete load of n words from load_words; corrupt flips checksum bits.
    task automatic applyStimulus(input int n, input bit gaps, input logic [7:0] corrupt, input bit mid_start);
        int hs, last_hs, seen, exp_cyc, exp_words;
        bit exp_err;
        logic [7:0] xacc, b;
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        checkOutput("rx_ready after start", 64'(bus.rx_ready), 64'd1);
        checkOutput("done after start", 64'(bus.done), 64'd0);
        checkOutput("error after start", 64'(bus.error), 64'd0);
        checkOutput("cpu_hold while loading", 64'(bus.cpu_hold), 64'd1);
        checkOutput("words_loaded after start", 64'(bus.words_loaded), 64'd0);
        sendByte(n[15:8], gaps, hs);
        sendByte(n[7:0], gaps, hs);
        last_hs   = hs;
        exp_err   = (n > MAX_WORDS);
        exp_words = exp_err ? 0 : n;
        exp_cyc   = last_hs;
        xacc      = 8'h00;
        if (!exp_err) begin
            for (int w = 0; w < n; w++) begin
                for (int k = 0; k < 4; k++) begin
                    b = load_words[w][31-8*k -: 8];
                    if (mid_start && w == 1 && k == 0) bus.start = 1'b1;
                    sendByte(b, gaps, hs);
                    bus.start = 1'b0;
                    xacc ^= b;
                    if (k == 3) begin
                        exp_q.push_back('{w, load_words[w], hs});
                        last_hs = hs;
                    end
                end
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            sendByte(xacc ^ corrupt, gaps, hs);
            exp_err = ((xacc ^ corrupt) != xacc);
            exp_cyc = hs;
`else
            exp_cyc = (n == 0) ? last_hs : last_hs + 1;
`endif
        end
        waitStatus(seen);
        checkOutput("status cycle", 64'(seen), 64'(exp_cyc));
        checkOutput("done level", 64'(bus.done), 64'(!exp_err));
        checkOutput("error level", 64'(bus.error), 64'(exp_err));
        checkOutput("cpu_hold at end", 64'(bus.cpu_hold), 64'(exp_err));
        checkOutput("words_loaded at end", 64'(bus.words_loaded), 64'(exp_words));
        checkOutput("writes outstanding", 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        int hs;
        bus.start    = 1'b0;
        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'h00;
        rst_n        = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checkResetOutputs("reset");
        rst_n = 1'b1;
        @(posedge clk); #1;

        load_words = '{32'h24080005, 32'h24090007};
        applyStimulus(2, 1'b0, 8'h00, 1'b0);

        load_words.delete();
        applyStimulus(0, 1'b0, 8'h00, 1'b0);

        applyStimulus(16'h0401, 1'b0, 8'h00, 1'b0);

`ifdef IMEM_LOADER_CHECKSUM_EN
        load_words = '{32'h12345678};
        applyStimulus(1, 1'b0, 8'h00, 1'b0);
        applyStimulus(1, 1'b0, 8'h01, 1'b0);
`endif

        fillRandom(3);
        applyStimulus(3, 1'b1, 8'h00, 1'b1);

        // Bytes offered while the loader is in DONE must not be consumed.
        bus.rx_data  = 8'hAA;
        bus.rx_valid = 1'b1;
        repeat (3) begin @(posedge clk); #1; end
        bus.rx_valid = 1'b0;
        checkOutput("idle bytes ignored", 64'(bus.words_loaded), 64'd3);
        checkOutput("done held", 64'(bus.done), 64'd1);

        // Reset in the middle of the second word.
        fillRandom(2);
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        sendByte(8'h00, 1'b0, hs);
        sendByte(8'h02, 1'b0, hs);
        for (int k = 0; k < 4; k++) begin
            sendByte(load_words[0][31-8*k -: 8], 1'b0, hs);
            if (k == 3) exp_q.push_back('{0, load_words[0], hs});
        end
        sendByte(load_words[1][31:24], 1'b0, hs);
        sendByte(load_words[1][23:16], 1'b0, hs);
        bus.rx_data  = load_words[1][15:8];
        bus.rx_valid = 1'b1;
        rst_n        = 1'b0;
        @(posedge clk); #1;
        checkResetOutputs("mid-load reset");
        bus.rx_valid = 1'b0;
        rst_n        = 1'b1;
        @(posedge clk); #1;
        checkOutput("writes outstanding after reset", 64'(exp_q.size()), 64'd0);
        fillRandom(2);
        applyStimulus(2, 1'b0, 8'h00, 1'b0);

        for (int t = 0; t < 4; t++) begin
            int n;
            n = $urandom_range(1, 5);
            fillRandom(n);
            applyStimulus(n, 1'b1, 8'h00, 1'b0);
        end

        fillRandom(MAX_WORDS);
        applyStimulus(MAX_WORDS, 1'b0, 8'h00, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
